// File: rtl/seg_scan_decoder_if.sv
// Display-bus readback interface.
//   i_led        : sampled segment lines {a..g}, bit6=a, bit0=g
//   i_digit_sel  : one-hot digit select, bit k selects digit k
//   o_bcd        : decoded frame, digit k at [4k+3:4k]
//   o_frame_valid: one-cycle pulse when o_bcd updates
//   o_frame_err  : current frame contains an illegal segment pattern
// master drives the display lines and observes the frame; slave is the decoder.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 6
);
  logic [6:0]              i_led;
  logic [NUM_DIGITS-1:0]   i_digit_sel;
  logic [4*NUM_DIGITS-1:0] o_bcd;
  logic                    o_frame_valid;
  logic                    o_frame_err;

  modport master (output i_led, i_digit_sel, input o_bcd, o_frame_valid, o_frame_err);
  modport slave  (input i_led, i_digit_sel, output o_bcd, o_frame_valid, o_frame_err);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: readback monitor for a multiplexed 7-segment display.
// Registers the segment and digit-select lines, waits for each digit to stay
// stable for SETTLE_CYCLES samples, decodes it back to BCD into a per-digit
// shadow slot and publishes all digits atomically once every digit was seen.
// Ports:
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   bus       : seg_scan_decoder_if.slave (segment/select in, frame out)

// One shadow slot: last captured nibble of a digit plus its illegal flag.
module seg_scan_slot (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_we,
  input  logic       i_clr_ill,
  input  logic [3:0] i_nib,
  input  logic       i_ill,
  output logic [3:0] o_nib,
  output logic       o_ill
);
  logic [3:0] nib_q, nib_d;
  logic       ill_q, ill_d;

  always_comb begin
    nib_d = nib_q;
    ill_d = i_clr_ill ? 1'b0 : ill_q;
    // a capture in the frame-publish cycle belongs to the next frame
    if (i_we) begin
      nib_d = i_nib;
      ill_d = i_ill;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      nib_q <= 4'hF;
      ill_q <= 1'b0;
    end else begin
      nib_q <= nib_d;
      ill_q <= ill_d;
    end
  end

  assign o_nib = nib_q;
  assign o_ill = ill_q;
endmodule

module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  seg_scan_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [6:0]              r_led_q, p_led_q;
  logic [NUM_DIGITS-1:0]   r_sel_q, p_sel_q;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_base;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic                    valid_q, err_q;

  logic                    sel_ok, sel_same, led_same, cap;
  logic [3:0]              dec_nib;
  logic                    dec_ill;
  logic [NUM_DIGITS-1:0][3:0] slot_nib;
  logic [NUM_DIGITS-1:0]   slot_ill;

  // Input stage plus one-cycle history used for the stability check.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_led_q <= '0;
      r_sel_q <= '0;
      p_led_q <= '0;
      p_sel_q <= '0;
    end else begin
      r_led_q <= bus.i_led;
      r_sel_q <= bus.i_digit_sel;
      p_led_q <= r_led_q;
      p_sel_q <= r_sel_q;
    end
  end

  assign sel_ok   = (r_sel_q != '0) && ((r_sel_q & (r_sel_q - 1'b1)) == '0);
  assign sel_same = (r_sel_q == p_sel_q);
  assign led_same = (r_led_q == p_led_q);

  // Segment pattern -> BCD. Blank is legal and maps to F.
  always_comb begin
    dec_ill = 1'b0;
    case (r_led_q)
      7'b1111110: dec_nib = 4'h0;
      7'b0110000: dec_nib = 4'h1;
      7'b1101101: dec_nib = 4'h2;
      7'b1111001: dec_nib = 4'h3;
      7'b0110011: dec_nib = 4'h4;
      7'b1011011: dec_nib = 4'h5;
      7'b1011111: dec_nib = 4'h6;
      7'b1110000: dec_nib = 4'h7;
      7'b1111111: dec_nib = 4'h8;
      7'b1111011: dec_nib = 4'h9;
      7'b0000000: dec_nib = 4'hF;
      default: begin
        dec_nib = 4'hE;
        dec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          cnt_d   = 4'd1;
          state_d = SETTLE;
        end else begin
          cnt_d = 4'd0;
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (sel_same && led_same) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd1;
        end
      end
      HOLD: begin
        // segment changes on the same digit are ignored once captured
        if (!sel_ok) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (!sel_same) begin
          cnt_d   = 4'd1;
          state_d = SETTLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
    // Capture evaluated on the updated count so SETTLE_CYCLES=1 captures on entry.
    if (state_d == SETTLE && cnt_d >= 4'(SETTLE_CYCLES)) begin
      cap     = 1'b1;
      state_d = HOLD;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_slot
      seg_scan_slot u_slot (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (cap & r_sel_q[k]),
        .i_clr_ill (pend_q),
        .i_nib     (dec_nib),
        .i_ill     (dec_ill),
        .o_nib     (slot_nib[k]),
        .o_ill     (slot_ill[k])
      );
    end
  endgenerate

  // The publish cycle clears the seen mask; a same-cycle capture starts the next frame.
  always_comb begin
    seen_base = pend_q ? '0 : seen_q;
    seen_d    = seen_base | (cap ? r_sel_q : '0);
    pend_d    = cap && (&(seen_base | r_sel_q));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seen_q  <= '0;
      pend_q  <= 1'b0;
      bcd_q   <= '1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      seen_q  <= seen_d;
      pend_q  <= pend_d;
      valid_q <= pend_q;
      if (pend_q) begin
        bcd_q <= slot_nib;
        err_q <= |slot_ill;
      end
    end
  end

  assign bus.o_bcd         = bcd_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_frame_err   = err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  localparam int N = 6;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.NUM_DIGITS(N)) bus ();
  seg_scan_decoder #(.NUM_DIGITS(N), .SETTLE_CYCLES(S)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [6:0] SEG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d < 10) ? SEG[d] : 7'b0000000;
  endfunction

  function automatic logic [4:0] m_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == SEG[i]) return {1'b0, 4'(i)};
    if (p == 7'b0) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  // Model: a "visit" is a maximal run of one constant valid select. Within a
  // visit the digit is captured once, the first time the segments have stayed
  // constant for S samples. Frames publish two edges after the final sample.
  logic [N-1:0] vis_sel, m_seen;
  bit           in_visit, captured;
  int           run, m_frames;
  logic [6:0]   run_led;
  logic [3:0]   m_sh [N];
  bit           m_ill [N];
  bit           p1, p2, p1_err, p2_err;
  logic [23:0]  p1_bcd, p2_bcd;
  logic [23:0]  e_bcd;
  bit           e_valid, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_visit = 0; captured = 0; run = 0; m_seen = '0; vis_sel = '0; run_led = '0;
      for (int i = 0; i < N; i++) begin m_sh[i] = 4'hF; m_ill[i] = 0; end
      p1 = 0; p2 = 0; e_bcd = '1; e_valid = 0; e_err = 0;
    end else begin
      logic [N-1:0] s;
      logic [6:0]   l;
      logic [4:0]   dv;
      s = bus.i_digit_sel;
      l = bus.i_led;
      e_valid = p2;
      if (p2) begin e_bcd = p2_bcd; e_err = p2_err; m_frames++; end
      p2 = p1; p2_bcd = p1_bcd; p2_err = p1_err; p1 = 0;
      if (!$onehot(s)) begin
        in_visit = 0;
      end else begin
        if (!in_visit || s != vis_sel) begin
          in_visit = 1; vis_sel = s; captured = 0; run = 1; run_led = l;
        end else if (l == run_led) begin
          run++;
        end else begin
          run = 1; run_led = l;
        end
        if (!captured && run >= S) begin
          captured = 1;
          dv = m_decode(l);
          for (int i = 0; i < N; i++)
            if (s[i]) begin m_sh[i] = dv[3:0]; m_ill[i] = dv[4]; end
          m_seen |= s;
          if (&m_seen) begin
            p1 = 1; p1_err = 0;
            for (int i = 0; i < N; i++) begin
              p1_bcd[4*i +: 4] = m_sh[i];
              p1_err |= m_ill[i];
              m_ill[i] = 0;
            end
            m_seen = '0;
          end
        end
      end
    end
  end

  int          d_frames = 0;
  logic [23:0] d_last_bcd = '1;
  logic        d_last_err = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("frame_valid", 32'(bus.o_frame_valid), 32'(e_valid));
      chk("bcd", 32'(bus.o_bcd), 32'(e_bcd));
      chk("frame_err", 32'(bus.o_frame_err), 32'(e_err));
      if (bus.o_frame_valid) begin
        d_frames++; d_last_bcd = bus.o_bcd; d_last_err = bus.o_frame_err;
      end
    end
  end

  task automatic put(input logic [N-1:0] s, input logic [6:0] p, input int n);
    bus.i_digit_sel = s;
    bus.i_led = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int k, input logic [3:0] d, input int n);
    put(N'(1) << k, seg_of(d), n);
  endtask

  task automatic scan(input logic [23:0] v);
    for (int k = 0; k < N; k++) show(k, v[4*k +: 4], 4);
    put('0, 7'b0, 5);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    chk({nm, "_rst_bcd"}, 32'(bus.o_bcd), 32'h00FF_FFFF);
    chk({nm, "_rst_valid"}, 32'(bus.o_frame_valid), 32'h0);
    chk({nm, "_rst_err"}, 32'(bus.o_frame_err), 32'h0);
    put('0, 7'b0, 2);
    rst_n = 1'b1;
  endtask

  task automatic expect_frame(input string nm, input int f0, input int m0, input int add,
                              input logic [23:0] val, input bit err);
    chk({nm, "_count"}, 32'(d_frames - f0), 32'(add));
    chk({nm, "_model_count"}, 32'(m_frames - m0), 32'(add));
    if (add > 0) begin
      chk({nm, "_bcd"}, 32'(d_last_bcd), 32'(val));
      chk({nm, "_err"}, 32'(d_last_err), 32'(err));
      chk({nm, "_model_bcd"}, 32'(e_bcd), 32'(val));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, m0;
    m_frames = 0;
    bus.i_digit_sel = '0;
    bus.i_led = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bus.o_bcd), 32'h00FF_FFFF);
    chk("reset_valid", 32'(bus.o_frame_valid), 32'h0);
    chk("reset_err", 32'(bus.o_frame_err), 32'h0);
    rst_n = 1'b1;
    put('0, 7'b0, 2);

    // clean scan
    f0 = d_frames; m0 = m_frames;
    scan(24'h954321);
    expect_frame("scan1", f0, m0, 1, 24'h954321, 1'b0);

    // digit 2 too short: no frame until a rescan supplies it
    do_reset("p2");
    f0 = d_frames; m0 = m_frames;
    for (int k = 0; k < N; k++) show(k, 4'(k), (k == 2) ? 1 : 4);
    put('0, 7'b0, 5);
    expect_frame("short", f0, m0, 0, 24'h0, 1'b0);
    scan(24'h543210);
    expect_frame("rescan", f0, m0, 1, 24'h543210, 1'b0);

    // illegal pattern on digit 3
    do_reset("p3");
    f0 = d_frames; m0 = m_frames;
    for (int k = 0; k < N; k++)
      if (k == 3) put(N'(1) << k, 7'b1000001, 4);
      else show(k, 4'(k + 1), 4);
    put('0, 7'b0, 5);
    expect_frame("illegal", f0, m0, 1, 24'h65E321, 1'b1);
    scan(24'h654321);
    expect_frame("clean", f0, m0, 2, 24'h654321, 1'b0);

    // multi-hot select in the middle of a scan
    do_reset("p4");
    f0 = d_frames; m0 = m_frames;
    show(0, 4'd7, 4); show(1, 4'd8, 4); show(2, 4'd9, 4);
    put(6'b000011, seg_of(4'd3), 5);
    expect_frame("multihot", f0, m0, 0, 24'h0, 1'b0);
    show(3, 4'd0, 4); show(4, 4'd1, 4); show(5, 4'd2, 4);
    put('0, 7'b0, 5);
    expect_frame("multihot_done", f0, m0, 1, 24'h210987, 1'b0);

    // segments glitch inside the settle window on digit 0
    do_reset("p5");
    f0 = d_frames; m0 = m_frames;
    show(0, 4'd8, 1); show(0, 4'd7, 1); show(0, 4'd7, 3);
    for (int k = 1; k < N; k++) show(k, 4'(k), 4);
    put('0, 7'b0, 5);
    expect_frame("glitch", f0, m0, 1, 24'h543217, 1'b0);

    // reset after three captures discards the partial frame
    show(0, 4'd6, 4); show(1, 4'd5, 4); show(2, 4'd4, 4);
    do_reset("mid");
    f0 = d_frames; m0 = m_frames;
    show(3, 4'd3, 4); show(4, 4'd2, 4); show(5, 4'd1, 4);
    put('0, 7'b0, 5);
    expect_frame("post_reset_partial", f0, m0, 0, 24'h0, 1'b0);
    scan(24'h123456);
    expect_frame("post_reset_full", f0, m0, 1, 24'h123456, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
